// File: rtl/cache_mem_arbiter_pkg.sv
// Shared pipeline types for the cache / memory arbiter.
// Provides the arbiter state and source enums, the line geometry constants
// and a helper that line-aligns a byte address.
package pipeline_types;

  localparam int LINE_BEATS = 8;
  localparam int BEAT_W     = 32;
  localparam int LINE_W     = LINE_BEATS * BEAT_W;

  typedef logic [255:0] bus256_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RDATA,
    WDATA,
    DONE
  } cache_arb_state_t;

  typedef enum logic [1:0] {
    SRC_IC,
    SRC_DC_RD,
    SRC_DC_WR
  } arb_src_t;

  // A line is 32 bytes, so the low five address bits are dropped.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:5], 5'b0_0000};
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Cache / memory arbiter: shares one 32-bit beat-serial memory port between
// ICache refills, DCache refills and DCache writebacks. One 256-bit line is
// moved per grant as 8 beats.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN selects round-robin between
// the ICache and DCache groups instead of fixed priority (wr > dc rd > ic rd).
module cache_mem_arbiter
  import pipeline_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ic_rd_req,
  input  logic [31:0]   ic_rd_addr,
  output logic          ic_ret_valid,
  output logic [255:0]  ic_ret_data,
  input  logic          dc_rd_req,
  input  logic [31:0]   dc_rd_addr,
  output logic          dc_ret_valid,
  output logic [255:0]  dc_ret_data,
  input  logic          dc_wr_req,
  input  logic [31:0]   dc_wr_addr,
  input  logic [255:0]  dc_wr_data,
  output logic          dc_wr_ok,
  output logic          mem_cmd_valid,
  input  logic          mem_cmd_ready,
  output logic          mem_cmd_we,
  output logic [31:0]   mem_cmd_addr,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [31:0]   mem_wdata
);

  cache_arb_state_t state_q, state_d;
  arb_src_t         src_q, grant_src;
  logic             we_q;
  logic [31:0]      addr_q, grant_addr;
  bus256_t          line_q, line_merged, ret_data_q;
  logic [2:0]       beat_q;
  logic             any_req, last_beat;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // Set when the DCache group won the most recent grant.
  logic dc_last_q;

  // DCache group wins unless the ICache is also waiting and DCache went last.
  function automatic arb_src_t pick_src(input logic ic, input logic dc_rd,
                                        input logic dc_wr, input logic dc_last);
    arb_src_t dc_src;
    dc_src = dc_wr ? SRC_DC_WR : SRC_DC_RD;
    if ((dc_wr || dc_rd) && !(ic && dc_last)) return dc_src;
    return SRC_IC;
  endfunction
`else
  // Fixed priority: writeback, then DCache refill, then ICache refill.
  function automatic arb_src_t pick_src(input logic ic, input logic dc_rd,
                                        input logic dc_wr);
    if (dc_wr) return SRC_DC_WR;
    if (dc_rd) return SRC_DC_RD;
    if (ic)    return SRC_IC;
    return SRC_IC;
  endfunction
`endif

  assign any_req   = ic_rd_req | dc_rd_req | dc_wr_req;
  assign last_beat = (beat_q == 3'(LINE_BEATS - 1));

  // Grant candidate and its address, only consumed in IDLE.
  always_comb begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    grant_src = pick_src(ic_rd_req, dc_rd_req, dc_wr_req, dc_last_q);
`else
    grant_src = pick_src(ic_rd_req, dc_rd_req, dc_wr_req);
`endif
    case (grant_src)
      SRC_DC_WR: grant_addr = dc_wr_addr;
      SRC_DC_RD: grant_addr = dc_rd_addr;
      default:   grant_addr = ic_rd_addr;
    endcase
  end

  // Line buffer with the current read beat merged into its slot.
  always_comb begin
    line_merged = line_q;
    line_merged[{beat_q, 5'b0_0000} +: BEAT_W] = mem_rdata;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = CMD;
      CMD:     if (mem_cmd_ready) state_d = we_q ? WDATA : RDATA;
      RDATA:   if (mem_rvalid && last_beat) state_d = DONE;
      WDATA:   if (mem_wready && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and latched transaction.
  always_comb begin
    mem_cmd_valid = (state_q == CMD);
    mem_cmd_we    = we_q;
    mem_cmd_addr  = addr_q;
    mem_wvalid    = (state_q == WDATA);
    mem_wdata     = mem_wvalid ? line_q[{beat_q, 5'b0_0000} +: BEAT_W] : '0;
    ic_ret_valid  = (state_q == DONE) && (src_q == SRC_IC);
    dc_ret_valid  = (state_q == DONE) && (src_q == SRC_DC_RD);
    dc_wr_ok      = (state_q == DONE) && (src_q == SRC_DC_WR);
    ic_ret_data   = ret_data_q;
    dc_ret_data   = ret_data_q;
  end

  // Transaction latch, beat counter, line buffer and returned line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= SRC_IC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      ret_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          src_q  <= grant_src;
          we_q   <= (grant_src == SRC_DC_WR);
          addr_q <= line_align(grant_addr);
          if (grant_src == SRC_DC_WR) line_q <= dc_wr_data;
        end
        CMD: if (mem_cmd_ready) beat_q <= '0;
        RDATA: if (mem_rvalid) begin
          line_q <= line_merged;
          beat_q <= beat_q + 3'd1;
          if (last_beat) ret_data_q <= line_merged;
        end
        WDATA: if (mem_wready) beat_q <= beat_q + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // Remember which group won, updated on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           dc_last_q <= 1'b0;
    else if (state_q == IDLE && any_req)  dc_last_q <= (grant_src != SRC_IC);
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed testbench for cache_mem_arbiter with a beat-serial memory responder.
module tb_cache_mem_arbiter;

  logic         clk, rst_n;
  logic         ic_rd_req, dc_rd_req, dc_wr_req;
  logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [255:0] dc_wr_data, ic_ret_data, dc_ret_data;
  logic         ic_ret_valid, dc_ret_valid, dc_wr_ok;
  logic         mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [31:0]  mem_cmd_addr, mem_rdata, mem_wdata;
  logic         mem_rvalid, mem_wvalid, mem_wready;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ic_cnt = 0, dc_cnt = 0, wr_cnt = 0;
  int ic_cyc = 0, wr_ok_beats = 0, stall_cnt = 0;
  int t0, c0, cnt0;
  bit auto_drop = 1'b1;
  bit wr_toggle = 1'b0;
  bit stall_pend = 1'b0;
  logic [31:0] stall_val;
  logic [31:0] rd_base = 32'h0;
  int          order_q[$];
  logic [31:0] cmd_addr_q[$];
  logic        cmd_we_q[$];
  logic [31:0] wbeat_q[$];
  logic [31:0] exp_addr[4];

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr),
    .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
    .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_ok(dc_wr_ok),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  function automatic int done_cnt(input int which);
    if (which == 0) return ic_cnt;
    if (which == 1) return dc_cnt;
    return wr_cnt;
  endfunction

  task automatic wait_cnt(input string tag, input int which, input int target, input int bound);
    int n;
    n = 0;
    while (done_cnt(which) < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt(which) < target) chk({tag, "_timeout"}, 256'(done_cnt(which)), 256'(target));
  endtask

  // Write-ready driver: constant high, or toggling every cycle.
  initial begin
    mem_wready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (wr_toggle) mem_wready = ~mem_wready;
      else           mem_wready = 1'b1;
    end
  end

  // Memory responder: logs commands and returns rd_base+k on read beats.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_cmd_valid && mem_cmd_ready) begin
        cmd_addr_q.push_back(mem_cmd_addr);
        cmd_we_q.push_back(mem_cmd_we);
        $display("txn cmd we=%0d addr=%h cycle %0d", mem_cmd_we, mem_cmd_addr, cyc);
        if (!mem_cmd_we) begin
          @(posedge clk);
          #1;
          for (int k = 0; k < 8; k++) begin
            if (!rst_n) break;
            mem_rvalid = 1'b1;
            mem_rdata  = rd_base + 32'(k);
            @(posedge clk);
            #1;
          end
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  // Completion / write-beat monitor; drops a request on its pulse.
  initial forever begin
    @(negedge clk);
    if (ic_ret_valid) begin
      ic_cnt++; ic_cyc = cyc; order_q.push_back(0);
      $display("txn ic_ret cycle %0d word0=%h", cyc, ic_ret_data[31:0]);
      if (auto_drop) ic_rd_req = 1'b0;
    end
    if (dc_ret_valid) begin
      dc_cnt++; order_q.push_back(1);
      $display("txn dc_ret cycle %0d word0=%h", cyc, dc_ret_data[31:0]);
      if (auto_drop) dc_rd_req = 1'b0;
    end
    if (dc_wr_ok) begin
      wr_cnt++; order_q.push_back(2); wr_ok_beats = wbeat_q.size();
      $display("txn dc_wr_ok cycle %0d beats=%0d", cyc, wbeat_q.size());
      if (auto_drop) dc_wr_req = 1'b0;
    end
    if (stall_pend && mem_wvalid) chk("wdata_hold", 256'(mem_wdata), 256'(stall_val));
    stall_pend = mem_wvalid && !mem_wready;
    stall_val  = mem_wdata;
    if (mem_wvalid && !mem_wready) stall_cnt++;
    if (mem_wvalid && mem_wready) wbeat_q.push_back(mem_wdata);
  end

  initial begin
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    ic_rd_addr = 0; dc_rd_addr = 0; dc_wr_addr = 0; dc_wr_data = '0;
    mem_cmd_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 256'(mem_cmd_valid), 256'(0));
    chk("rst_wvalid", 256'(mem_wvalid), 256'(0));
    chk("rst_ic_ret_valid", 256'(ic_ret_valid), 256'(0));
    chk("rst_ic_ret_data", ic_ret_data, 256'(0));
    chk("rst_cmd_addr", 256'(mem_cmd_addr), 256'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // ICache read only, minimum latency
    @(posedge clk); #1;
    t0 = cyc; rd_base = 32'h0; ic_rd_addr = 32'h1C00_0014; ic_rd_req = 1'b1;
    @(negedge clk);
    chk("t1_cmd_valid_c0", 256'(mem_cmd_valid), 256'(0));
    @(negedge clk);
    chk("t1_cmd_valid_c1", 256'(mem_cmd_valid), 256'(1));
    chk("t1_cmd_addr", 256'(mem_cmd_addr), 256'(32'h1C00_0000));
    chk("t1_cmd_we", 256'(mem_cmd_we), 256'(0));
    wait_cnt("t1_ic", 0, 1, 40);
    chk("t1_latency", 256'(ic_cyc - t0), 256'(10));
    chk("t1_word0", 256'(ic_ret_data[31:0]), 256'(0));
    chk("t1_word7", 256'(ic_ret_data[255:224]), 256'(7));
    chk("t1_no_dc", 256'(dc_cnt + wr_cnt), 256'(0));

    // Simultaneous requests, priority order
    repeat (2) @(posedge clk); #1;
    order_q.delete(); c0 = cmd_addr_q.size();
    rd_base = 32'h10;
    dc_wr_addr = 32'h2000_0040; dc_wr_data = {8{32'hA5A5_0000}};
    dc_rd_addr = 32'h3000_0021; ic_rd_addr = 32'h4000_0007;
    dc_wr_req = 1'b1; dc_rd_req = 1'b1; ic_rd_req = 1'b1;
    wait_cnt("t2_ic", 0, 2, 80);
    chk("t2_n_done", 256'(order_q.size()), 256'(3));
    chk("t2_n_cmd", 256'(cmd_addr_q.size() - c0), 256'(3));
    if (order_q.size() >= 3 && cmd_addr_q.size() >= c0 + 3) begin
      chk("t2_order0", 256'(order_q[0]), 256'(2));
      chk("t2_order1", 256'(order_q[1]), 256'(1));
      chk("t2_order2", 256'(order_q[2]), 256'(0));
      chk("t2_addr0", 256'(cmd_addr_q[c0]), 256'(32'h2000_0040));
      chk("t2_we0", 256'(cmd_we_q[c0]), 256'(1));
      chk("t2_addr1", 256'(cmd_addr_q[c0+1]), 256'(32'h3000_0020));
      chk("t2_addr2", 256'(cmd_addr_q[c0+2]), 256'(32'h4000_0000));
    end
    chk("t2_ic_word0", 256'(ic_ret_data[31:0]), 256'(32'h10));

    // Writeback with toggling write-ready
    repeat (2) @(posedge clk); #1;
    wbeat_q.delete(); stall_cnt = 0; wr_toggle = 1'b1;
    for (int k = 0; k < 8; k++) dc_wr_data[32*k +: 32] = 32'(k + 1);
    dc_wr_addr = 32'h0000_801F; dc_wr_req = 1'b1;
    wait_cnt("t3_wr", 2, 2, 60);
    wr_toggle = 1'b0;
    chk("t3_beats_at_ok", 256'(wr_ok_beats), 256'(8));
    chk("t3_stalls_seen", 256'(stall_cnt != 0), 256'(1));
    if (wbeat_q.size() >= 8)
      for (int k = 0; k < 8; k++) chk($sformatf("t3_beat%0d", k), 256'(wbeat_q[k]), 256'(k + 1));
    chk("t3_addr", 256'(cmd_addr_q[cmd_addr_q.size()-1]), 256'(32'h0000_8000));

    // Command-ready stall for 5 cycles
    repeat (2) @(posedge clk); #1;
    mem_cmd_ready = 1'b0;
    @(posedge clk); #1;
    t0 = cyc; rd_base = 32'h20; ic_rd_addr = 32'h0000_1234; ic_rd_req = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_valid_c%0d", i), 256'(mem_cmd_valid), 256'(1));
      chk($sformatf("t4_addr_c%0d", i), 256'(mem_cmd_addr), 256'(32'h0000_1220));
    end
    @(posedge clk); #1; mem_cmd_ready = 1'b1;
    wait_cnt("t4_ic", 0, 3, 40);
    chk("t4_latency", 256'(ic_cyc - t0), 256'(15));
    chk("t4_word0", 256'(ic_ret_data[31:0]), 256'(32'h20));
    chk("t4_word7", 256'(ic_ret_data[255:224]), 256'(32'h27));

    // Reset in the middle of a read
    repeat (2) @(posedge clk); #1;
    cnt0 = ic_cnt; rd_base = 32'h200; ic_rd_addr = 32'h7000_0000; ic_rd_req = 1'b1;
    repeat (6) @(posedge clk);
    #1; rst_n = 1'b0; ic_rd_req = 1'b0;
    #1;
    chk("t5_cmd_valid", 256'(mem_cmd_valid), 256'(0));
    chk("t5_cmd_addr", 256'(mem_cmd_addr), 256'(0));
    chk("t5_ic_ret_valid", 256'(ic_ret_valid), 256'(0));
    chk("t5_ic_ret_data", ic_ret_data, 256'(0));
    chk("t5_dc_ret_data", dc_ret_data, 256'(0));
    chk("t5_wvalid", 256'(mem_wvalid), 256'(0));
    repeat (3) @(posedge clk); #1; rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_no_ret", 256'(ic_cnt), 256'(cnt0));
    @(posedge clk); #1;
    t0 = cyc; rd_base = 32'h300; ic_rd_req = 1'b1;
    wait_cnt("t5_ic", 0, cnt0 + 1, 40);
    chk("t5_latency", 256'(ic_cyc - t0), 256'(10));
    chk("t5_word0", 256'(ic_ret_data[31:0]), 256'(32'h300));
    chk("t5_word7", 256'(ic_ret_data[255:224]), 256'(32'h307));

    // ICache and DCache reads held continuously
    repeat (2) @(posedge clk); #1;
    auto_drop = 1'b0; c0 = cmd_addr_q.size(); rd_base = 32'h40;
    dc_rd_addr = 32'h5000_0000; ic_rd_addr = 32'h6000_0000;
    dc_rd_req = 1'b1; ic_rd_req = 1'b1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_addr = '{32'h5000_0000, 32'h6000_0000, 32'h5000_0000, 32'h6000_0000};
`else
    exp_addr = '{32'h5000_0000, 32'h5000_0000, 32'h5000_0000, 32'h5000_0000};
`endif
    for (int n = 0; n < 100 && cmd_addr_q.size() < c0 + 4; n++) @(negedge clk);
    dc_rd_req = 1'b0; ic_rd_req = 1'b0;
    chk("t6_n_cmd", 256'(cmd_addr_q.size() >= c0 + 4), 256'(1));
    if (cmd_addr_q.size() >= c0 + 4)
      for (int k = 0; k < 4; k++) chk($sformatf("t6_grant%0d", k), 256'(cmd_addr_q[c0+k]), 256'(exp_addr[k]));
    repeat (25) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
